// File: rtl/tff_count_ctrl_if.sv
// Handshake and data bundle between the counter controller and its T flip-flop bank.
// master drives requests and the bank state; slave is the controller.
interface tff_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
  logic             up;
  logic             oneshot;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] t_out;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, stop, load, load_val, term_val, up, oneshot, q_in,
    input  t_out, busy, done, wrap
  );

  modport slave (
    input  start, stop, load, load_val, term_val, up, oneshot, q_in,
    output t_out, busy, done, wrap
  );
endinterface

// File: rtl/tff_count_ctrl.sv
// Sequencing controller for a WIDTH-bit T flip-flop counter bank: drives per-bit
// toggles for parallel load, up/down counting, terminal detection and auto-reload.
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input logic             c,
  input logic             rs,
  tff_count_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] reload_q;
  logic             wrap_q;
  logic             wrap_set;
  logic [WIDTH-1:0] t_next;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             at_term;

  assign at_term = (bus.q_in == bus.term_val);

  // A bit toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic up_run;
    logic dn_run;
    up_run = 1'b1;
    dn_run = 1'b1;
    up_t   = '0;
    dn_t   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = up_run;
      dn_t[i] = dn_run;
      up_run  = up_run & bus.q_in[i];
      dn_run  = dn_run & ~bus.q_in[i];
    end
  end

  always_ff @(posedge c) begin
    if (rs) begin
      state_q  <= IDLE;
      reload_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_set;
      if (state_q == IDLE && bus.load) begin
        reload_q <= bus.load_val;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.stop)                      state_d = IDLE;
        else if (at_term && bus.oneshot)   state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Toggle pattern is gated by rs so the bank sees no toggles while resetting.
  always_comb begin
    t_next   = '0;
    wrap_set = 1'b0;
    if (!rs) begin
      case (state_q)
        IDLE: begin
          if (bus.load) t_next = bus.q_in ^ bus.load_val;
        end
        RUN: begin
          if (!bus.stop) begin
            if (at_term) begin
              if (!bus.oneshot) begin
                t_next   = bus.q_in ^ reload_q;
                wrap_set = 1'b1;
              end
            end else begin
              t_next = bus.up ? up_t : dn_t;
            end
          end
        end
        default: t_next = '0;
      endcase
    end
  end

  assign bus.t_out = t_next;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl: a behavioural T flip-flop bank closes the loop,
// and a table of per-cycle vectors plus a bounded run-to-done sequence check it.
module tb_tff_count_ctrl;

  typedef struct {
    logic       rs;
    logic       start;
    logic       stop;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] term_val;
    logic       up;
    logic       oneshot;
    logic [3:0] exp_q;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_wrap;
    logic       chk_t;
    logic [3:0] exp_t;
  } vec_t;

  logic c;
  logic rs;
  logic [3:0] bank_q;
  int tests;
  int failed;
  vec_t vecs[$];

  tff_count_ctrl_if #(.WIDTH(4)) bus ();

  tff_count_ctrl #(.WIDTH(4)) dut (
    .c  (c),
    .rs (rs),
    .bus(bus)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  // The T flip-flop bank shares clock and reset with the controller.
  initial bank_q = 4'hA;
  always @(posedge c) begin
    if (rs) bank_q <= 4'h0;
    else    bank_q <= bank_q ^ bus.t_out;
  end
  assign bus.q_in = bank_q;

  function automatic vec_t vec(input logic v_rs, v_st, v_sp, v_ld,
                               input logic [3:0] v_lv, v_tv,
                               input logic v_up, v_os,
                               input logic [3:0] v_q,
                               input logic v_b, v_d, v_w, v_ct,
                               input logic [3:0] v_t);
    vec_t v;
    v.rs = v_rs; v.start = v_st; v.stop = v_sp; v.load = v_ld;
    v.load_val = v_lv; v.term_val = v_tv; v.up = v_up; v.oneshot = v_os;
    v.exp_q = v_q; v.exp_busy = v_b; v.exp_done = v_d; v.exp_wrap = v_w;
    v.chk_t = v_ct; v.exp_t = v_t;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    rs           = v.rs;
    bus.start    = v.start;
    bus.stop     = v.stop;
    bus.load     = v.load;
    bus.load_val = v.load_val;
    bus.term_val = v.term_val;
    bus.up       = v.up;
    bus.oneshot  = v.oneshot;
  endtask

  task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  initial begin
    int n;
    bit seen;
    tests  = 0;
    failed = 0;

    // Reset
    vecs.push_back(vec(1,1,0,1, 4'd7,4'd0,0,0, 4'd0, 0,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd0,0,0, 4'd0, 0,0,0, 1,4'h0));
    // One-shot up 0..5
    vecs.push_back(vec(0,1,0,1, 4'd0,4'd5,1,1, 4'd0, 0,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd5,1,1, 4'd0, 1,0,0, 1,4'h1));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd5,1,1, 4'd1, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd5,1,1, 4'd2, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd5,1,1, 4'd3, 1,0,0, 1,4'h7));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd5,1,1, 4'd4, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd5,1,1, 4'd5, 1,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd5,1,1, 4'd5, 1,1,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd5,1,1, 4'd5, 0,0,0, 1,4'h0));
    // Auto-reload 3..6
    vecs.push_back(vec(0,1,0,1, 4'd3,4'd6,1,0, 4'd5, 0,0,0, 1,4'h6));
    vecs.push_back(vec(0,0,0,0, 4'd3,4'd6,1,0, 4'd3, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd3,4'd6,1,0, 4'd4, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd3,4'd6,1,0, 4'd5, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd3,4'd6,1,0, 4'd6, 1,0,0, 1,4'h5));
    vecs.push_back(vec(0,0,0,0, 4'd3,4'd6,1,0, 4'd3, 1,0,1, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd3,4'd6,1,0, 4'd4, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd3,4'd6,1,0, 4'd5, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd3,4'd6,1,0, 4'd6, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,1,0, 4'd3,4'd6,1,0, 4'd3, 1,0,1, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd3,4'd6,1,0, 4'd3, 0,0,0, 1,4'h0));
    // Down 9..2
    vecs.push_back(vec(0,1,0,1, 4'd9,4'd2,0,1, 4'd3, 0,0,0, 1,4'hA));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd9, 1,0,0, 1,4'h1));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd8, 1,0,0, 1,4'hF));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd7, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd6, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd5, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd4, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd3, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd2, 1,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd2, 1,1,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd2,0,1, 4'd2, 0,0,0, 1,4'h0));
    // Down through zero 1..14
    vecs.push_back(vec(0,1,0,1, 4'd1,4'd14,0,1, 4'd2, 0,0,0, 1,4'h3));
    vecs.push_back(vec(0,0,0,0, 4'd1,4'd14,0,1, 4'd1, 1,0,0, 1,4'h1));
    vecs.push_back(vec(0,0,0,0, 4'd1,4'd14,0,1, 4'd0, 1,0,0, 1,4'hF));
    vecs.push_back(vec(0,0,0,0, 4'd1,4'd14,0,1, 4'd15,1,0,0, 1,4'h1));
    vecs.push_back(vec(0,0,0,0, 4'd1,4'd14,0,1, 4'd14,1,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd1,4'd14,0,1, 4'd14,1,1,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd1,4'd14,0,1, 4'd14,0,0,0, 1,4'h0));
    // Up through all-ones 14..1
    vecs.push_back(vec(0,1,0,1, 4'd14,4'd1,1,1, 4'd14,0,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd14,4'd1,1,1, 4'd14,1,0,0, 1,4'h1));
    vecs.push_back(vec(0,0,0,0, 4'd14,4'd1,1,1, 4'd15,1,0,0, 1,4'hF));
    vecs.push_back(vec(0,0,0,0, 4'd14,4'd1,1,1, 4'd0, 1,0,0, 1,4'h1));
    vecs.push_back(vec(0,0,0,0, 4'd14,4'd1,1,1, 4'd1, 1,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd14,4'd1,1,1, 4'd1, 1,1,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd14,4'd1,1,1, 4'd1, 0,0,0, 1,4'h0));
    // Terminal already reached on first RUN cycle; start ignored in DONE
    vecs.push_back(vec(0,1,0,1, 4'd9,4'd9,1,1, 4'd1, 0,0,0, 1,4'h8));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd9,1,1, 4'd9, 1,0,0, 1,4'h0));
    vecs.push_back(vec(0,1,0,0, 4'd9,4'd9,1,1, 4'd9, 1,1,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd9,4'd9,1,1, 4'd9, 0,0,0, 1,4'h0));
    // Load without start
    vecs.push_back(vec(0,0,0,1, 4'd6,4'd9,1,1, 4'd9, 0,0,0, 1,4'hF));
    vecs.push_back(vec(0,0,0,0, 4'd6,4'd9,1,1, 4'd6, 0,0,0, 1,4'h0));
    // Stop at 4, stop ignored in IDLE, restart, then rs mid-run at 7
    vecs.push_back(vec(0,1,0,1, 4'd0,4'd12,1,1, 4'd6, 0,0,0, 1,4'h6));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd12,1,1, 4'd0, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd12,1,1, 4'd1, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd12,1,1, 4'd2, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd12,1,1, 4'd3, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,1,0, 4'd0,4'd12,1,1, 4'd4, 1,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,1,0, 4'd0,4'd12,1,1, 4'd4, 0,0,0, 1,4'h0));
    vecs.push_back(vec(0,1,0,0, 4'd0,4'd12,1,1, 4'd4, 0,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd12,1,1, 4'd4, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd12,1,1, 4'd5, 1,0,0, 0,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd12,1,1, 4'd6, 1,0,0, 0,4'h0));
    vecs.push_back(vec(1,0,0,0, 4'd0,4'd12,1,1, 4'd7, 1,0,0, 1,4'h0));
    vecs.push_back(vec(0,0,0,0, 4'd0,4'd12,1,1, 4'd0, 0,0,0, 1,4'h0));

    apply_stimulus(vecs[0]);

    foreach (vecs[i]) begin
      @(negedge c);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d q", i),    bank_q,           vecs[i].exp_q);
      check_output($sformatf("v%0d busy", i), {3'b0, bus.busy}, {3'b0, vecs[i].exp_busy});
      check_output($sformatf("v%0d done", i), {3'b0, bus.done}, {3'b0, vecs[i].exp_done});
      check_output($sformatf("v%0d wrap", i), {3'b0, bus.wrap}, {3'b0, vecs[i].exp_wrap});
      if (vecs[i].chk_t) check_output($sformatf("v%0d t_out", i), bus.t_out, vecs[i].exp_t);
    end

    // Up count from 5 to terminal 0 through the all-ones wrap: 12 RUN cycles then DONE.
    @(negedge c);
    apply_stimulus(vec(0,1,0,1, 4'd5,4'd0,1,1, 4'd0, 0,0,0, 0,4'h0));
    @(negedge c);
    apply_stimulus(vec(0,0,0,0, 4'd5,4'd0,1,1, 4'd0, 0,0,0, 0,4'h0));
    n = 1;
    seen = 1'b0;
    while (n <= 30 && !seen) begin
      #1;
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge c);
        n++;
      end
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("[TB] FAIL wrap_run timeout: got no done in %0d cycles, expected done", n - 1);
    end else begin
      check_output("wrap_run cycles", n[3:0], 4'd13);
      check_output("wrap_run q", bank_q, 4'd0);
    end

    @(negedge c);
    #1;
    check_output("wrap_run idle busy", {3'b0, bus.busy}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
